// File: rtl/mem_router_pkg.sv
// mem_router_pkg -- shared types and constants for the mem_router slice.
//   state_e        : router FSM states (IDLE, BUSY, RESP)
//   DEF_SLV_BASE   : default packed region bases (2 x 32 bit, index 0 in LSBs)
//   DEF_SLV_MASK   : default packed region masks
//   idx_w()        : width of a region index for a given region count
//   sat_inc()      : 32-bit increment that sticks at all-ones
package mem_router_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [63:0] DEF_SLV_BASE = {32'h0000_7F00, 32'h0000_2000};
  localparam logic [63:0] DEF_SLV_MASK = {32'hFFFF_FF00, 32'hFFFF_F000};

  // A single region still needs a 1-bit index signal.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mem_region_decode.sv
// mem_region_decode -- combinational address-to-region decode.
//   addr   in  DW     request address
//   match  out N_SLV  per-region match, (addr & mask[i]) == base[i]
//   idx    out IW     lowest matching region index (0 when no hit)
//   hit    out 1      at least one region matches
module mem_region_decode
  import mem_router_pkg::*;
#(
  parameter int unsigned             N_SLV    = 2,
  parameter int unsigned             DW       = 32,
  parameter logic [N_SLV*DW-1:0]     SLV_BASE = DEF_SLV_BASE,
  parameter logic [N_SLV*DW-1:0]     SLV_MASK = DEF_SLV_MASK,
  parameter int unsigned             IW       = idx_w(N_SLV)
) (
  input  logic [DW-1:0]    addr,
  output logic [N_SLV-1:0] match,
  output logic [IW-1:0]    idx,
  output logic             hit
);

  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < N_SLV; i++) begin
      match[i] = ((addr & SLV_MASK[i*DW +: DW]) == SLV_BASE[i*DW +: DW]);
    end
  end

  // Scan upward and keep the first hit so overlapping regions resolve
  // to the lowest index.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int unsigned i = 0; i < N_SLV; i++) begin
      if (match[i] && !hit) begin
        hit = 1'b1;
        idx = i[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_router.sv
// mem_router -- routes a single upstream load/store to one of N_SLV regions.
//   clk, rstn        clock (rising edge), asynchronous active-low reset
//   re, we          upstream read / write request, held until done
//   addr, wdata     request address / store data
//   rdata           load data, valid while done is high
//   done, err       one-cycle completion pulse / error flag qualified by done
//   s_re, s_we      per-region read / write strobes
//   s_addr, s_wdata latched address / store data shared by all regions
//   s_rdata, s_done per-region read data / completion
//   acc_cnt         per-region completed-access counters (32 bit each, saturating)
//   err_cnt         error completion counter (saturating)
// Build option: define MEM_ROUTER_TIMEOUT_EN to abort a BUSY access after
// TIMEOUT_CYC cycles without s_done; otherwise BUSY waits indefinitely.
module mem_router
  import mem_router_pkg::*;
#(
  parameter int unsigned         N_SLV       = 2,
  parameter int unsigned         DW          = 32,
  parameter logic [N_SLV*DW-1:0] SLV_BASE    = DEF_SLV_BASE,
  parameter logic [N_SLV*DW-1:0] SLV_MASK    = DEF_SLV_MASK,
  parameter int unsigned         TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                re,
  input  logic                we,
  input  logic [DW-1:0]       addr,
  input  logic [DW-1:0]       wdata,
  output logic [DW-1:0]       rdata,
  output logic                done,
  output logic                err,
  output logic [N_SLV-1:0]    s_re,
  output logic [N_SLV-1:0]    s_we,
  output logic [DW-1:0]       s_addr,
  output logic [DW-1:0]       s_wdata,
  input  logic [N_SLV*DW-1:0] s_rdata,
  input  logic [N_SLV-1:0]    s_done,
  output logic [N_SLV*32-1:0] acc_cnt,
  output logic [31:0]         err_cnt
);

  localparam int unsigned IW = idx_w(N_SLV);

  state_e                  state_q, state_d;
  logic                    op_we_q, op_we_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [DW-1:0]           s_addr_q, s_addr_d;
  logic [DW-1:0]           s_wdata_q, s_wdata_d;
  logic [N_SLV-1:0]        s_re_q, s_re_d;
  logic [N_SLV-1:0]        s_we_q, s_we_d;
  logic [DW-1:0]           rdata_q, rdata_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [N_SLV-1:0][31:0]  acc_cnt_q, acc_cnt_d;
  logic [31:0]             err_cnt_q, err_cnt_d;

  logic [N_SLV-1:0]        unused_match;
  logic [IW-1:0]           dec_idx;
  logic                    dec_hit;
  logic                    sel_done;
  logic [DW-1:0]           sel_rdata;

`ifdef MEM_ROUTER_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = (TIMEOUT_CYC == 0) ? 32'd0 : 32'(TIMEOUT_CYC - 1);
  logic [31:0] tmo_q, tmo_d;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
`endif

  mem_region_decode #(
    .N_SLV    (N_SLV),
    .DW       (DW),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK),
    .IW       (IW)
  ) u_decode (
    .addr  (addr),
    .match (unused_match),
    .idx   (dec_idx),
    .hit   (dec_hit)
  );

  // Only the latched region's completion and data are observed.
  assign sel_done  = s_done[idx_q];
  assign sel_rdata = s_rdata[idx_q*DW +: DW];

  always_comb begin
    state_d   = state_q;
    op_we_d   = op_we_q;
    idx_d     = idx_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_re_d    = s_re_q;
    s_we_d    = s_we_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    done_d    = 1'b0;
    acc_cnt_d = acc_cnt_q;
    err_cnt_d = err_cnt_q;
`ifdef MEM_ROUTER_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (re || we) begin
          if ((re ^ we) && dec_hit) begin
            op_we_d         = we;
            idx_d           = dec_idx;
            s_addr_d        = addr;
            s_wdata_d       = wdata;
            s_re_d          = '0;
            s_we_d          = '0;
            s_re_d[dec_idx] = re;
            s_we_d[dec_idx] = we;
`ifdef MEM_ROUTER_TIMEOUT_EN
            tmo_d           = '0;
`endif
            state_d         = BUSY;
          end else begin
            rdata_d   = '0;
            err_d     = 1'b1;
            done_d    = 1'b1;
            err_cnt_d = sat_inc(err_cnt_q);
            state_d   = RESP;
          end
        end
      end

      BUSY: begin
        if (sel_done) begin
          rdata_d          = op_we_q ? '0 : sel_rdata;
          err_d            = 1'b0;
          done_d           = 1'b1;
          s_re_d           = '0;
          s_we_d           = '0;
          acc_cnt_d[idx_q] = sat_inc(acc_cnt_q[idx_q]);
          state_d          = RESP;
        end
`ifdef MEM_ROUTER_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          rdata_d   = '0;
          err_d     = 1'b1;
          done_d    = 1'b1;
          s_re_d    = '0;
          s_we_d    = '0;
          err_cnt_d = sat_inc(err_cnt_q);
          state_d   = RESP;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
`endif
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      op_we_q   <= 1'b0;
      idx_q     <= '0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_re_q    <= '0;
      s_we_q    <= '0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      acc_cnt_q <= '0;
      err_cnt_q <= '0;
`ifdef MEM_ROUTER_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      op_we_q   <= op_we_d;
      idx_q     <= idx_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_re_q    <= s_re_d;
      s_we_q    <= s_we_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
      err_q     <= err_d;
      acc_cnt_q <= acc_cnt_d;
      err_cnt_q <= err_cnt_d;
`ifdef MEM_ROUTER_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign rdata   = rdata_q;
  assign done    = done_q;
  assign err     = err_q;
  assign s_re    = s_re_q;
  assign s_we    = s_we_q;
  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;
  assign acc_cnt = acc_cnt_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_mem_router.sv
// tb_mem_router -- self-checking bench for mem_router (N_SLV=2, DW=32).
// A responsive slave model answers strobes after slv_wait strobe cycles
// (0 = never); expected responses are queued when a request is issued and
// popped when done is seen.
module tb_mem_router;

`ifdef MEM_ROUTER_TIMEOUT_EN
  localparam int unsigned TMO = 4;
`else
  localparam int unsigned TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        re, we;
  logic [31:0] addr, wdata, rdata;
  logic        done, err;
  logic [1:0]  s_re, s_we, s_done;
  logic [31:0] s_addr, s_wdata;
  logic [63:0] s_rdata;
  logic [63:0] acc_cnt;
  logic [31:0] err_cnt;

  always #5 clk = ~clk;

  mem_router #(
    .N_SLV       (2),
    .DW          (32),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .re      (re),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .done    (done),
    .err     (err),
    .s_re    (s_re),
    .s_we    (s_we),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_rdata (s_rdata),
    .s_done  (s_done),
    .acc_cnt (acc_cnt),
    .err_cnt (err_cnt)
  );

  // Slave model: completion after slv_wait cycles of strobe, plus injectable stray pulses.
  int unsigned slv_wait = 1;
  int unsigned busy_cnt = 0;
  logic [1:0]  resp  = 2'b00;
  logic [1:0]  stray = 2'b00;

  always @(negedge clk) begin
    if ((s_re | s_we) != 2'b00) begin
      busy_cnt = busy_cnt + 1;
      resp = (slv_wait != 0 && busy_cnt >= slv_wait) ? (s_re | s_we) : 2'b00;
    end else begin
      busy_cnt = 0;
      resp = 2'b00;
    end
  end

  assign s_done = resp | stray;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          tests_run = 0;
  int          fails = 0;
  logic [31:0] exp_acc0, exp_acc1, exp_err_cnt;

  function automatic int tb_region(input logic [31:0] a);
    if ((a & 32'hFFFF_F000) == 32'h0000_2000) return 0;
    if ((a & 32'hFFFF_FF00) == 32'h0000_7F00) return 1;
    return -1;
  endfunction

  task automatic issue(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    re = r; we = w; addr = a; wdata = d;
  endtask

  task automatic release_req();
    re = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  // Advance cycle by cycle until done (bounded); records latency and strobe activity.
  task automatic wait_done(input int max_cyc, output int cyc, output bit seen,
                           output int stb_cyc, output logic [1:0] stb_re, output logic [1:0] stb_we);
    cyc = 0; seen = 1'b0; stb_cyc = 0; stb_re = 2'b00; stb_we = 2'b00;
    while (!seen && cyc < max_cyc) begin
      @(posedge clk); #1;
      cyc++;
      if ((s_re | s_we) != 2'b00) stb_cyc++;
      stb_re = stb_re | s_re;
      stb_we = stb_we | s_we;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; re = 1'b0; we = 1'b0; addr = '0; wdata = '0; s_rdata = '0;
    stray = 2'b00; slv_wait = 1;
    #12;
    tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b, expected 0", done); end
    tests_run++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b, expected 0", err); end
    tests_run++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h, expected 0", rdata); end
    tests_run++; if ((s_re | s_we) !== 2'b00) begin fails++; $display("FAIL reset_strobes: got %b, expected 00", s_re | s_we); end
    tests_run++; if (acc_cnt !== 64'h0) begin fails++; $display("FAIL reset_acc_cnt: got %h, expected 0", acc_cnt); end
    tests_run++; if (err_cnt !== 32'h0) begin fails++; $display("FAIL reset_err_cnt: got %h, expected 0", err_cnt); end
    @(posedge clk); #1;
    rstn = 1'b1;
    exp_acc0 = 0; exp_acc1 = 0; exp_err_cnt = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_read();
    int cyc, sc; bit seen; logic [1:0] sr, sw; exp_t e;
    s_rdata = {32'hCAFE_0001, 32'h0000_1234};
    slv_wait = 1;
    sb.push_back('{rdata: 32'h0000_1234, err: 1'b0});
    exp_acc0++;
    issue(1'b1, 1'b0, 32'h0000_2004, 32'h0);
    wait_done(20, cyc, seen, sc, sr, sw);
    e = sb.pop_front();
    tests_run++; if (!seen) begin fails++; $display("FAIL read_done: got no done, expected done within 20 cycles"); end
    tests_run++; if (cyc !== 2) begin fails++; $display("FAIL read_latency: got %0d, expected 2", cyc); end
    tests_run++; if (rdata !== e.rdata) begin fails++; $display("FAIL read_rdata: got %h, expected %h", rdata, e.rdata); end
    tests_run++; if (err !== e.err) begin fails++; $display("FAIL read_err: got %b, expected %b", err, e.err); end
    tests_run++; if (sr !== 2'b01 || sw !== 2'b00) begin fails++; $display("FAIL read_strobe: got re=%b we=%b, expected re=01 we=00", sr, sw); end
    tests_run++; if (s_addr !== 32'h0000_2004) begin fails++; $display("FAIL read_s_addr: got %h, expected 00002004", s_addr); end
    tests_run++; if (acc_cnt[31:0] !== exp_acc0) begin fails++; $display("FAIL read_acc0: got %0d, expected %0d", acc_cnt[31:0], exp_acc0); end
    release_req();
    tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL read_done_pulse: got %b, expected 0", done); end
  endtask

  task automatic test_write();
    int cyc, sc; bit seen; logic [1:0] sr, sw; exp_t e;
    slv_wait = 3;
    sb.push_back('{rdata: 32'h0, err: 1'b0});
    exp_acc1++;
    issue(1'b0, 1'b1, 32'h0000_7F10, 32'h0000_00AA);
    wait_done(20, cyc, seen, sc, sr, sw);
    e = sb.pop_front();
    tests_run++; if (!seen) begin fails++; $display("FAIL write_done: got no done, expected done within 20 cycles"); end
    tests_run++; if (sc !== 3) begin fails++; $display("FAIL write_strobe_cycles: got %0d, expected 3", sc); end
    tests_run++; if (cyc !== 4) begin fails++; $display("FAIL write_latency: got %0d, expected 4", cyc); end
    tests_run++; if (sw !== 2'b10 || sr !== 2'b00) begin fails++; $display("FAIL write_strobe: got re=%b we=%b, expected re=00 we=10", sr, sw); end
    tests_run++; if (s_wdata !== 32'h0000_00AA) begin fails++; $display("FAIL write_s_wdata: got %h, expected 000000aa", s_wdata); end
    tests_run++; if (rdata !== e.rdata || err !== e.err) begin fails++; $display("FAIL write_resp: got rdata=%h err=%b, expected rdata=%h err=%b", rdata, err, e.rdata, e.err); end
    tests_run++; if (acc_cnt[63:32] !== exp_acc1) begin fails++; $display("FAIL write_acc1: got %0d, expected %0d", acc_cnt[63:32], exp_acc1); end
    release_req();
  endtask

  task automatic test_errors();
    int cyc, sc; bit seen; logic [1:0] sr, sw; exp_t e;
    // Unmapped read
    slv_wait = 1;
    sb.push_back('{rdata: 32'h0, err: 1'b1});
    exp_err_cnt++;
    issue(1'b1, 1'b0, 32'h0000_9000, 32'h0);
    wait_done(20, cyc, seen, sc, sr, sw);
    e = sb.pop_front();
    tests_run++; if (!seen || cyc !== 1) begin fails++; $display("FAIL unmapped_latency: got seen=%0d cyc=%0d, expected seen=1 cyc=1", seen, cyc); end
    tests_run++; if ((sr | sw) !== 2'b00) begin fails++; $display("FAIL unmapped_strobe: got %b, expected 00", sr | sw); end
    tests_run++; if (rdata !== e.rdata || err !== e.err) begin fails++; $display("FAIL unmapped_resp: got rdata=%h err=%b, expected rdata=%h err=%b", rdata, err, e.rdata, e.err); end
    tests_run++; if (err_cnt !== exp_err_cnt) begin fails++; $display("FAIL unmapped_err_cnt: got %0d, expected %0d", err_cnt, exp_err_cnt); end
    release_req();
    // re and we together on a mapped address
    sb.push_back('{rdata: 32'h0, err: 1'b1});
    exp_err_cnt++;
    issue(1'b1, 1'b1, 32'h0000_2000, 32'h1);
    wait_done(20, cyc, seen, sc, sr, sw);
    e = sb.pop_front();
    tests_run++; if (!seen || cyc !== 1) begin fails++; $display("FAIL both_latency: got seen=%0d cyc=%0d, expected seen=1 cyc=1", seen, cyc); end
    tests_run++; if ((sr | sw) !== 2'b00) begin fails++; $display("FAIL both_strobe: got %b, expected 00", sr | sw); end
    tests_run++; if (rdata !== e.rdata || err !== e.err) begin fails++; $display("FAIL both_resp: got rdata=%h err=%b, expected rdata=%h err=%b", rdata, err, e.rdata, e.err); end
    tests_run++; if (err_cnt !== exp_err_cnt) begin fails++; $display("FAIL both_err_cnt: got %0d, expected %0d", err_cnt, exp_err_cnt); end
    tests_run++; if (acc_cnt !== {exp_acc1, exp_acc0}) begin fails++; $display("FAIL err_acc_unchanged: got %h, expected %h", acc_cnt, {exp_acc1, exp_acc0}); end
    release_req();
  endtask

  task automatic test_stray();
    int cyc, sc; bit seen; logic [1:0] sr, sw; exp_t e;
    // Completions while idle must do nothing
    stray = 2'b11;
    repeat (3) begin
      @(posedge clk); #1;
      tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL stray_idle_done: got %b, expected 0", done); end
    end
    stray = 2'b00;
    // Region 1 completes while region 0 is being accessed
    s_rdata = {32'h1111_1111, 32'h0BAD_F00D};
    slv_wait = 3;
    sb.push_back('{rdata: 32'h0BAD_F00D, err: 1'b0});
    exp_acc0++;
    stray = 2'b10;
    issue(1'b1, 1'b0, 32'h0000_2010, 32'h0);
    wait_done(20, cyc, seen, sc, sr, sw);
    e = sb.pop_front();
    tests_run++; if (!seen || cyc !== 4) begin fails++; $display("FAIL stray_latency: got seen=%0d cyc=%0d, expected seen=1 cyc=4", seen, cyc); end
    tests_run++; if (rdata !== e.rdata || err !== e.err) begin fails++; $display("FAIL stray_resp: got rdata=%h err=%b, expected rdata=%h err=%b", rdata, err, e.rdata, e.err); end
    release_req();
    stray = 2'b00;
    tests_run++; if (acc_cnt !== {exp_acc1, exp_acc0}) begin fails++; $display("FAIL stray_acc: got %h, expected %h", acc_cnt, {exp_acc1, exp_acc0}); end
    tests_run++; if (err_cnt !== exp_err_cnt) begin fails++; $display("FAIL stray_err_cnt: got %0d, expected %0d", err_cnt, exp_err_cnt); end
  endtask

  task automatic test_back_to_back();
    int cyc, sc; bit seen; logic [1:0] sr, sw; exp_t e, x;
    int unsigned kind, w; logic opw, r, wv; logic [31:0] a, d; int ri; bit is_err;
    for (int k = 0; k < 12; k++) begin
      kind = $urandom_range(0, 3);
      opw  = 1'($urandom_range(0, 1));
      w    = $urandom_range(1, 3);
      d    = $urandom;
      s_rdata = {$urandom, $urandom};
      case (kind)
        0:       a = 32'h0000_2000 | ($urandom & 32'h0000_0FFF);
        1:       a = 32'h0000_7F00 | ($urandom & 32'h0000_00FF);
        2:       a = 32'h0000_9000 | ($urandom & 32'h0000_00FF);
        default: a = 32'h0000_2000 | ($urandom & 32'h0000_0FFF);
      endcase
      r  = (kind == 3) ? 1'b1 : !opw;
      wv = (kind == 3) ? 1'b1 : opw;
      ri = tb_region(a);
      is_err = (ri < 0) || (r && wv);
      x.err   = is_err;
      x.rdata = (is_err || wv) ? 32'h0 : s_rdata[ri*32 +: 32];
      if (is_err) exp_err_cnt++;
      else if (ri == 0) exp_acc0++;
      else exp_acc1++;
      sb.push_back(x);
      slv_wait = w;
      issue(r, wv, a, d);
      wait_done(20, cyc, seen, sc, sr, sw);
      e = sb.pop_front();
      tests_run++; if (!seen || cyc !== (is_err ? 1 : int'(w) + 1)) begin fails++; $display("FAIL b2b_latency[%0d]: got seen=%0d cyc=%0d, expected cyc=%0d", k, seen, cyc, is_err ? 1 : int'(w) + 1); end
      tests_run++; if (rdata !== e.rdata || err !== e.err) begin fails++; $display("FAIL b2b_resp[%0d]: got rdata=%h err=%b, expected rdata=%h err=%b", k, rdata, err, e.rdata, e.err); end
      release_req();
    end
    tests_run++; if (acc_cnt !== {exp_acc1, exp_acc0}) begin fails++; $display("FAIL b2b_acc: got %h, expected %h", acc_cnt, {exp_acc1, exp_acc0}); end
    tests_run++; if (err_cnt !== exp_err_cnt) begin fails++; $display("FAIL b2b_err_cnt: got %0d, expected %0d", err_cnt, exp_err_cnt); end
  endtask

`ifdef MEM_ROUTER_TIMEOUT_EN
  task automatic test_timeout();
    int cyc, sc; bit seen; logic [1:0] sr, sw; exp_t e;
    slv_wait = 0;
    sb.push_back('{rdata: 32'h0, err: 1'b1});
    exp_err_cnt++;
    issue(1'b1, 1'b0, 32'h0000_2000, 32'h0);
    wait_done(20, cyc, seen, sc, sr, sw);
    e = sb.pop_front();
    tests_run++; if (!seen) begin fails++; $display("FAIL timeout_done: got no done, expected done within 20 cycles"); end
    tests_run++; if (sc !== 4) begin fails++; $display("FAIL timeout_strobe_cycles: got %0d, expected 4", sc); end
    tests_run++; if (rdata !== e.rdata || err !== e.err) begin fails++; $display("FAIL timeout_resp: got rdata=%h err=%b, expected rdata=%h err=%b", rdata, err, e.rdata, e.err); end
    tests_run++; if (acc_cnt !== {exp_acc1, exp_acc0}) begin fails++; $display("FAIL timeout_acc: got %h, expected %h", acc_cnt, {exp_acc1, exp_acc0}); end
    tests_run++; if (err_cnt !== exp_err_cnt) begin fails++; $display("FAIL timeout_err_cnt: got %0d, expected %0d", err_cnt, exp_err_cnt); end
    release_req();
    slv_wait = 1;
  endtask
`else
  task automatic test_hold();
    int cyc, sc; bit seen; logic [1:0] sr, sw; exp_t e;
    s_rdata = {32'h7777_0042, 32'h0};
    slv_wait = 0;
    sb.push_back('{rdata: 32'h7777_0042, err: 1'b0});
    exp_acc1++;
    issue(1'b1, 1'b0, 32'h0000_7F04, 32'h0);
    wait_done(40, cyc, seen, sc, sr, sw);
    tests_run++; if (seen) begin fails++; $display("FAIL hold_no_done: got done after %0d cycles, expected none", cyc); end
    tests_run++; if (sc !== 40 || s_re !== 2'b10) begin fails++; $display("FAIL hold_strobe: got cycles=%0d s_re=%b, expected cycles=40 s_re=10", sc, s_re); end
    slv_wait = 1;
    wait_done(5, cyc, seen, sc, sr, sw);
    e = sb.pop_front();
    tests_run++; if (!seen || cyc !== 1) begin fails++; $display("FAIL hold_release: got seen=%0d cyc=%0d, expected seen=1 cyc=1", seen, cyc); end
    tests_run++; if (rdata !== e.rdata || err !== e.err) begin fails++; $display("FAIL hold_resp: got rdata=%h err=%b, expected rdata=%h err=%b", rdata, err, e.rdata, e.err); end
    release_req();
  endtask
`endif

  task automatic test_reset_busy();
    int cyc, sc; bit seen; logic [1:0] sr, sw; exp_t e;
    slv_wait = 0;
    issue(1'b1, 1'b0, 32'h0000_2000, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests_run++; if (s_re !== 2'b01) begin fails++; $display("FAIL rstbusy_pre_strobe: got %b, expected 01", s_re); end
    #2;
    rstn = 1'b0;
    #1;
    tests_run++; if ((s_re | s_we) !== 2'b00) begin fails++; $display("FAIL rstbusy_strobe: got %b, expected 00", s_re | s_we); end
    tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL rstbusy_done: got %b, expected 0", done); end
    tests_run++; if (acc_cnt !== 64'h0 || err_cnt !== 32'h0) begin fails++; $display("FAIL rstbusy_counters: got acc=%h err=%h, expected 0", acc_cnt, err_cnt); end
    tests_run++; if (s_addr !== 32'h0) begin fails++; $display("FAIL rstbusy_s_addr: got %h, expected 0", s_addr); end
    re = 1'b0;
    exp_acc0 = 0; exp_acc1 = 0; exp_err_cnt = 0;
    @(posedge clk); #1;
    tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL rstbusy_no_done: got %b, expected 0", done); end
    rstn = 1'b1;
    @(posedge clk); #1;
    // Normal service afterwards
    slv_wait = 2;
    sb.push_back('{rdata: 32'h0, err: 1'b0});
    exp_acc1++;
    issue(1'b0, 1'b1, 32'h0000_7F20, 32'h0000_0055);
    wait_done(20, cyc, seen, sc, sr, sw);
    e = sb.pop_front();
    tests_run++; if (!seen || cyc !== 3) begin fails++; $display("FAIL rstbusy_next_latency: got seen=%0d cyc=%0d, expected seen=1 cyc=3", seen, cyc); end
    tests_run++; if (rdata !== e.rdata || err !== e.err) begin fails++; $display("FAIL rstbusy_next_resp: got rdata=%h err=%b, expected rdata=%h err=%b", rdata, err, e.rdata, e.err); end
    tests_run++; if (acc_cnt !== {exp_acc1, exp_acc0}) begin fails++; $display("FAIL rstbusy_next_acc: got %h, expected %h", acc_cnt, {exp_acc1, exp_acc0}); end
    release_req();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_errors();
    test_stray();
    test_back_to_back();
`ifdef MEM_ROUTER_TIMEOUT_EN
    test_timeout();
`else
    test_hold();
`endif
    test_reset_busy();
    tests_run++; if (sb.size() != 0) begin fails++; $display("FAIL scoreboard_empty: got %0d entries, expected 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_router.md
MEM_ROUTER -- requirements
Module: mem_router

Interface
REQ-001 Parameter N_SLV, default 2, number of downstream regions (1..8).
REQ-002 Parameter DW, default 32, data and address width.
REQ-003 Parameter SLV_BASE, default {32'h0000_7F00, 32'h0000_2000}, packed N_SLV*DW region bases, index 0 in LSBs.
REQ-004 Parameter SLV_MASK, default {32'hFFFF_FF00, 32'hFFFF_F000}, packed N_SLV*DW region masks.
REQ-005 Parameter TIMEOUT_CYC, default 255, BUSY-cycle limit when the timeout is compiled in.
REQ-006 Clock and reset are decided: one clock; reset asynchronous, active-low.
REQ-007 clk  in  1  clock, rising edge.
REQ-008 rstn  in  1  asynchronous active-low reset.
REQ-009 re / we  in  1 each  upstream read / write request, held until done.
REQ-010 addr / wdata  in  DW each  request address / store data.
REQ-011 rdata  out  DW  load data, valid in the done cycle.
REQ-012 done / err  out  1 each  one-cycle completion pulse / error flag qualified by done.
REQ-013 s_re / s_we  out  N_SLV each  per-region read / write strobes.
REQ-014 s_addr / s_wdata  out  DW each  latched address / store data, shared by all regions.
REQ-015 s_rdata  in  N_SLV*DW  per-region read data; s_done  in  N_SLV  per-region completion.
REQ-016 acc_cnt  out  N_SLV*32  per-region completed-access counters; err_cnt  out  32  error counter.

Function
REQ-017 Region i SHALL match when (addr & SLV_MASK[i]) == SLV_BASE[i]; on overlap, the lowest index SHALL win.
REQ-018 The FSM SHALL have exactly the states IDLE, BUSY and RESP.
REQ-019 In IDLE with exactly one of re/we high and a matching region, the block SHALL latch addr, wdata, op and index, then go to BUSY.
REQ-020 In IDLE with an unmapped address, or with re and we both high, the block SHALL go to RESP with err=1 and rdata=0, asserting no strobe.
REQ-021 In BUSY, s_re[idx] or s_we[idx] SHALL stay high every cycle until s_done[idx]; all other strobes SHALL stay 0.
REQ-022 In the s_done[idx] cycle, the block SHALL capture s_rdata[idx] (0 for writes), increment acc_cnt[idx] and go to RESP.
REQ-023 RESP SHALL assert done for exactly one cycle with registered rdata/err, then return to IDLE; re/we SHALL be ignored in RESP and BUSY.
REQ-024 Latency: with a zero-wait slave, done SHALL rise 2 cycles after the request cycle; an error request SHALL see done 1 cycle after.
REQ-025 s_done from a non-selected region, or in IDLE/RESP, SHALL be ignored.
REQ-026 Each error completion SHALL increment err_cnt; all counters SHALL saturate at 32'hFFFF_FFFF.

Reset
REQ-027 rstn low SHALL asynchronously force IDLE and zero all outputs, latched registers and counters, including during BUSY (the access is aborted without done).

Configuration
REQ-028 With MEM_ROUTER_TIMEOUT_EN defined, a BUSY cycle counter SHALL abort the access after TIMEOUT_CYC cycles without s_done: it drops the strobe, goes to RESP with err=1 and rdata=0, and leaves acc_cnt unchanged.
REQ-029 Without MEM_ROUTER_TIMEOUT_EN, BUSY SHALL wait indefinitely, and no timeout counter SHALL be synthesised.

Structure
REQ-030 The package mem_router_pkg SHALL hold the state enum and the default base/mask constants.
REQ-031 The combinational decode (match vector, priority index, hit flag) SHALL live in the sub-module mem_region_decode.

Verification
REQ-032 Read at 0x2004 with s_done[0] in the first BUSY cycle and s_rdata[0]=0x1234 -> done 2 cycles later, rdata=0x1234, err=0, acc_cnt[0]=1.
REQ-033 Write 0xAA to 0x7F10 with s_done[1] after 3 cycles -> s_we[1] high for 3 cycles, s_wdata=0xAA, done with err=0, acc_cnt[1]=1.
REQ-034 Read at 0x9000 (unmapped) -> no strobe, done next cycle, err=1, rdata=0, err_cnt=1.
REQ-035 re and we both high at 0x2000 -> err=1, no strobe.
REQ-036 With MEM_ROUTER_TIMEOUT_EN defined and TIMEOUT_CYC=4, s_done held low -> strobe drops after 4 cycles, done with err=1.
REQ-037 rstn pulsed low mid-BUSY -> strobes drop immediately, no done, counters=0, next request serviced normally.
